// File: rtl/kernel_pr_wide_packer.sv
// kernel_pr_wide_packer: drains PR FIFO words and packs them LSB-first into wide beats.
// Optional macro PR_PACKER_PERF_EN adds the stall_cycles performance counter output.
module kernel_pr_wide_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int LANES     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic [CNT_WIDTH-1:0]         num_words,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic                         in_empty_n,
  input  logic [IN_WIDTH-1:0]          in_dout,
  output logic                         in_read,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_WIDTH*LANES-1:0]    out_data,
  output logic [IN_WIDTH*LANES/8-1:0]  out_keep,
  output logic                         out_last
`ifdef PR_PACKER_PERF_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int LW = $clog2(LANES);
  localparam int KB = IN_WIDTH / 8;
  localparam int BW = IN_WIDTH * LANES;
  localparam int KW = BW / 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT,
    DONE
  } state_t;

  state_t               state;
  logic [LW-1:0]        lane;
  logic [CNT_WIDTH-1:0] remaining;
  logic [BW-1:0]        data_q;
  logic [KW-1:0]        keep_q;
  logic                 rem_nz;
  logic                 pop;

  assign rem_nz = (remaining != '0);
  // Pop gated by reset so a mid-job reset never consumes a FIFO word.
  assign pop = (state == FILL) & in_empty_n & rem_nz & ~reset;

  assign in_read   = pop;
  assign ap_idle   = (state == IDLE);
  assign ap_done   = (state == DONE);
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) & ~rem_nz;
  assign out_data  = data_q;
  assign out_keep  = keep_q;

  // Job sequencing, lane packing and beat hand-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lane      <= '0;
      remaining <= '0;
      data_q    <= '0;
      keep_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            remaining <= num_words;
            lane      <= '0;
            data_q    <= '0;
            keep_q    <= '0;
            state     <= (num_words == '0) ? DONE : FILL;
          end
        end
        FILL: begin
          if (pop) begin
            for (int k = 0; k < LANES; k++) begin
              if (lane == LW'(k)) begin
                data_q[k*IN_WIDTH +: IN_WIDTH] <= in_dout;
                keep_q[k*KB +: KB]             <= '1;
              end
            end
            lane      <= lane + 1'b1;
            remaining <= remaining - 1'b1;
            if (lane == LW'(LANES - 1) ||
                remaining == CNT_WIDTH'(1)) begin
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!rem_nz) begin
              state <= DONE;
            end else begin
              lane   <= '0;
              data_q <= '0;
              keep_q <= '0;
              state  <= FILL;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PR_PACKER_PERF_EN
  logic stall_inc;

  assign stall_inc = ((state == FILL) & ~in_empty_n & rem_nz) |
                     ((state == EMIT) & ~out_ready);

  // Saturating count of input-starved and output-backpressured cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (state == IDLE && ap_start) begin
      stall_cycles <= '0;
    end else if (stall_inc && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_pr_wide_packer.sv
// Directed self-checking bench for kernel_pr_wide_packer.
// Covers full/partial beats, empty job, backpressure, starved input and mid-job reset.
module tb_kernel_pr_wide_packer;

  localparam int W  = 32;
  localparam int L  = 16;
  localparam int BW = W * L;
  localparam int KW = BW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start;
  logic [31:0]   num_words;
  logic          ap_idle;
  logic          ap_done;
  logic          in_empty_n;
  logic [W-1:0]  in_dout;
  logic          in_read;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [KW-1:0] out_keep;
  logic          out_last;
`ifdef PR_PACKER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int            first_pop;
  int            last_pop;
  logic [KW-1:0] last_keep;
  logic [BW-1:0] last_data;

  always #5 clk = ~clk;

  kernel_pr_wide_packer dut (
    .clk        (clk),
    .reset      (reset),
    .ap_start   (ap_start),
    .num_words  (num_words),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .in_empty_n (in_empty_n),
    .in_dout    (in_dout),
    .in_read    (in_read),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last)
`ifdef PR_PACKER_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input int n, input bit tog, input int stall,
                         input logic [31:0] bv, input string nm);
    logic [31:0]   q[$];
    int            pops    = 0;
    int            beats   = 0;
    int            left    = n;
    int            stalled = 0;
    int            last_acc = -100;
    int            done_at = -1;
    int            dones   = 0;
    int            exp_st  = 0;
    int            cnt;
    bit            prev_pop   = 1'b0;
    bit            prev_valid = 1'b0;
    logic [BW-1:0] snap_d;
    logic [KW-1:0] snap_k;
    logic          snap_l;
    logic [BW-1:0] ed;
    logic [KW-1:0] ek;
    first_pop  = -1;
    last_pop   = -1;
    num_words  = n;
    ap_start   = 1'b1;
    out_ready  = 1'b1;
    in_empty_n = 1'b1;
    in_dout    = bv;
    @(posedge clk); #1;
    ap_start = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      in_empty_n = tog ? t[0] : 1'b1;
      in_dout    = bv + pops;
      out_ready  = !(out_valid && stalled < stall);
      #1;
      chk({nm, "_underflow"}, BW'(in_read & ~in_empty_n), '0);
      if (out_valid) begin
        chk({nm, "_no_pop_emit"}, BW'(in_read), '0);
        if (!prev_valid) begin
          chk({nm, "_valid_after_pop"}, BW'(prev_pop), BW'(1));
          snap_d = out_data;
          snap_k = out_keep;
          snap_l = out_last;
        end else begin
          chk({nm, "_hold_data"}, out_data, snap_d);
          chk({nm, "_hold_keep"}, BW'(out_keep), BW'(snap_k));
          chk({nm, "_hold_last"}, BW'(out_last), BW'(snap_l));
        end
      end
      if ((!in_empty_n && !out_valid && pops < n && done_at < 0) ||
          (out_valid && !out_ready)) begin
        exp_st++;
      end
      if (out_valid && !out_ready) stalled++;
      if (out_valid && out_ready) begin
        ed  = '0;
        ek  = '0;
        cnt = (q.size() < L) ? q.size() : L;
        for (int k = 0; k < cnt; k++) begin
          ed[k*W +: W] = q.pop_front();
          ek[k*4 +: 4] = 4'hF;
        end
        left -= cnt;
        chk({nm, "_data"}, out_data, ed);
        chk({nm, "_keep"}, BW'(out_keep), BW'(ek));
        chk({nm, "_last"}, BW'(out_last), BW'(left == 0));
        last_keep = out_keep;
        last_data = out_data;
        beats++;
        last_acc = t;
        stalled  = 0;
      end
      if (ap_done) begin
        dones++;
        if (done_at < 0) done_at = t;
      end
      if (in_read) begin
        q.push_back(bv + pops);
        pops++;
        if (first_pop < 0) first_pop = t;
        last_pop = t;
      end
      prev_pop   = in_read;
      prev_valid = out_valid;
      @(posedge clk); #1;
      if (done_at >= 0 && t == done_at + 1) break;
    end
    chk({nm, "_pops"}, BW'(pops), BW'(n));
    chk({nm, "_beats"}, BW'(beats), BW'((n + L - 1) / L));
    chk({nm, "_done_pulses"}, BW'(dones), BW'(1));
    if (n > 0) chk({nm, "_done_lat"}, BW'(done_at), BW'(last_acc + 1));
    else       chk({nm, "_done_lat"}, BW'(done_at), BW'(1));
    chk({nm, "_idle_end"}, BW'(ap_idle), BW'(1));
`ifdef PR_PACKER_PERF_EN
    chk({nm, "_stall_cycles"}, BW'(stall_cycles), BW'(exp_st));
`endif
  endtask

  initial begin
    logic [BW-1:0] z;
    z          = '0;
    reset      = 1'b1;
    ap_start   = 1'b0;
    num_words  = '0;
    in_empty_n = 1'b1;
    in_dout    = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle",  BW'(ap_idle),   BW'(1));
    chk("rst_done",  BW'(ap_done),   z);
    chk("rst_read",  BW'(in_read),   z);
    chk("rst_valid", BW'(out_valid), z);
    chk("rst_last",  BW'(out_last),  z);
    chk("rst_data",  out_data,       z);
    chk("rst_keep",  BW'(out_keep),  z);
`ifdef PR_PACKER_PERF_EN
    chk("rst_stall", BW'(stall_cycles), z);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    run_job(16, 1'b0, 0, 32'h1000_0000, "t1");
    chk("t1_first_pop", BW'(first_pop), BW'(1));
    chk("t1_pop_span", BW'(last_pop - first_pop), BW'(15));
    chk("t1_keep_all", BW'(last_keep), BW'({KW{1'b1}}));

    run_job(20, 1'b0, 0, 32'h2000_0000, "t2");
    chk("t2_tail_keep", BW'(last_keep), BW'(64'h0000_0000_0000_FFFF));
    chk("t2_tail_zero", BW'(last_data[BW-1:4*W]), z);

    run_job(0, 1'b0, 0, 32'h3000_0000, "t3");

    run_job(16, 1'b0, 5, 32'h4000_0000, "t4");

    run_job(32, 1'b1, 0, 32'h5000_0000, "t5");

    num_words  = 16;
    in_empty_n = 1'b1;
    in_dout    = 32'hDEAD_0000;
    ap_start   = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_dout = 32'hDEAD_0000 + i;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_no_pop", BW'(in_read), z);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_idle",  BW'(ap_idle),   BW'(1));
    chk("t6_valid", BW'(out_valid), z);
    chk("t6_data",  out_data,       z);
    chk("t6_keep",  BW'(out_keep),  z);
    @(posedge clk); #1;
    run_job(16, 1'b0, 0, 32'h6000_0000, "t6b");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
